lockstep_checker: RTL and testbench



---
 rtl/lockstep_checker.sv | 209 ++++++++++++++++++++
 tb/tb_lockstep_checker.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lockstep_checker.sv
// N-channel lockstep comparator: model samples queue in per-channel FIFOs and are popped/compared
// in order against DUT samples. Optional stall watchdog is built when LOCKSTEP_WATCHDOG_EN is defined.
module lockstep_checker #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int CHANNELS    = 2,
  parameter int TIMEOUT     = 20000,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                        Clock,
  input  logic                        nReset,
  input  logic                        Enable,
  input  logic [CHANNELS-1:0]         ModelValid,
  input  logic [CHANNELS*WIDTH-1:0]   ModelData,
  input  logic [CHANNELS-1:0]         DutValid,
  input  logic [CHANNELS*WIDTH-1:0]   DutData,
  output logic [CHANNELS-1:0]         Mismatch,
  output logic [15:0]                 ErrCount,
  output logic [$clog2(CHANNELS):0]   FirstErrChan,
  output logic [WIDTH-1:0]            FirstErrModel,
  output logic [WIDTH-1:0]            FirstErrDut,
  output logic                        Overflow,
  output logic                        Underflow,
  output logic                        Timeout,
  output logic                        Halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam int CW = $clog2(CHANNELS) + 1;
  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state_q, state_d;

  logic [WIDTH-1:0] mem    [CHANNELS][DEPTH];
  logic [PW-1:0]    rd_ptr [CHANNELS];
  logic [PW-1:0]    wr_ptr [CHANNELS];
  logic [OW-1:0]    occ    [CHANNELS];

  logic                active;
  logic [CHANNELS-1:0] do_write, do_read, mis, ovf, unf, err;
  logic [WIDTH-1:0]    err_model [CHANNELS];
  logic [WIDTH-1:0]    err_dut   [CHANNELS];
  logic [16:0]         err_sum;
  logic [CW-1:0]       first_chan;
  logic [WIDTH-1:0]    first_model, first_dut;
  logic                first_seen, err_q, timeout_hit;

  assign active = (state_q == RUN);
  assign Halted = (state_q == HALT);

  // Per-channel push/pop decode; an empty FIFO with push+pop compares the incoming sample directly.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    do_write = '0;
    do_read  = '0;
    mis      = '0;
    ovf      = '0;
    unf      = '0;
    err      = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      err_model[c] = '0;
      err_dut[c]   = '0;
      if (active && DutValid[c]) begin
        err_dut[c] = DutData[c*WIDTH +: WIDTH];
        if (occ[c] == '0) begin
          if (ModelValid[c]) begin
            mis[c]       = (ModelData[c*WIDTH +: WIDTH] != DutData[c*WIDTH +: WIDTH]);
            err_model[c] = ModelData[c*WIDTH +: WIDTH];
          end else begin
            unf[c] = 1'b1;
          end
        end else begin
          do_read[c]   = 1'b1;
          do_write[c]  = ModelValid[c];
          mis[c]       = (mem[c][rd_ptr[c]] != DutData[c*WIDTH +: WIDTH]);
          err_model[c] = mem[c][rd_ptr[c]];
        end
      end else if (active && ModelValid[c]) begin
        if (occ[c] == OCC_FULL) begin
          ovf[c]       = 1'b1;
          err_model[c] = ModelData[c*WIDTH +: WIDTH];
        end else begin
          do_write[c] = 1'b1;
        end
      end
      err[c] = mis[c] | ovf[c] | unf[c];
    end
  end

  // Error total for this cycle and lowest-numbered failing channel.
  always_comb begin
    // NOTE: blocking assignments here build a running sum; state registers below use non-blocking.
    err_sum     = {1'b0, ErrCount};
    first_chan  = '0;
    first_model = '0;
    first_dut   = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      err_sum = err_sum + 17'(err[c]);
      if (err[c]) begin
        first_chan  = CW'(c);
        first_model = err_model[c];
        first_dut   = err_dut[c];
      end
    end
  end

  // NOTE: FIFO storage is not reset; clearing pointers and occupancy is enough to flush it.
  always_ff @(posedge Clock) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (do_write[c]) mem[c][wr_ptr[c]] <= ModelData[c*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        occ[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (do_write[c]) wr_ptr[c] <= wr_ptr[c] + PW'(1);
        if (do_read[c])  rd_ptr[c] <= rd_ptr[c] + PW'(1);
        if (do_write[c] && !do_read[c])      occ[c] <= occ[c] + OW'(1);
        else if (do_read[c] && !do_write[c]) occ[c] <= occ[c] - OW'(1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      Mismatch      <= '0;
      ErrCount      <= '0;
      FirstErrChan  <= '0;
      FirstErrModel <= '0;
      FirstErrDut   <= '0;
      Overflow      <= 1'b0;
      Underflow     <= 1'b0;
      first_seen    <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      Mismatch <= mis;
      ErrCount <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      err_q    <= |err;
      if (|ovf) Overflow  <= 1'b1;
      if (|unf) Underflow <= 1'b1;
      if (|err && !first_seen) begin
        first_seen    <= 1'b1;
        FirstErrChan  <= first_chan;
        FirstErrModel <= first_model;
        FirstErrDut   <= first_dut;
      end
    end
  end

`ifdef LOCKSTEP_WATCHDOG_EN
  logic [14:0] wd_cnt;
  logic        any_busy;

  always_comb begin
    any_busy = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (occ[c] != '0) any_busy = 1'b1;
    end
  end

  assign timeout_hit = active && any_busy && !(|DutValid) && (wd_cnt == 15'(TIMEOUT - 1));

  // Counts stalled RUN cycles; any DUT activity or fully drained FIFOs restart it.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      wd_cnt  <= '0;
      Timeout <= 1'b0;
    end else begin
      if (|DutValid || !any_busy) wd_cnt <= '0;
      else if (active)            wd_cnt <= wd_cnt + 15'd1;
      if (timeout_hit) Timeout <= 1'b1;
    end
  end
`else
  // TIMEOUT only matters when the watchdog is built.
  localparam int unused_timeout = TIMEOUT;
  assign timeout_hit = 1'b0;
  assign Timeout     = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (!nReset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // A registered error halts the block one edge later, so compares in that cycle still count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (Enable) state_d = RUN;
      RUN: begin
        if (timeout_hit || ((STOP_ON_ERR != 0) && err_q)) state_d = HALT;
        else if (!Enable)                                  state_d = IDLE;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lockstep_checker.sv
// Self-checking bench for lockstep_checker: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations and a STOP_ON_ERR instance.
module tb_lockstep_checker;
  localparam int WIDTH    = 32;
  localparam int DEPTH    = 4;
  localparam int CHANNELS = 2;
  localparam int TIMEOUT  = 16;
  localparam int S_IDLE = 0, S_RUN = 1, S_HALT = 2;

  logic        clk = 1'b0;
  logic        rst_n, enable;
  logic [1:0]  mv, dv;
  logic [63:0] md, dd;
  logic [1:0]  mismatch;
  logic [15:0] err_count;
  logic [1:0]  first_chan;
  logic [31:0] first_model, first_dut;
  logic        overflow, underflow, timeout, halted;

  logic        s_enable;
  logic [1:0]  s_mv, s_dv;
  logic [63:0] s_md, s_dd;
  logic [1:0]  s_mismatch;
  logic [15:0] s_err_count;
  logic [1:0]  s_first_chan;
  logic [31:0] s_first_model, s_first_dut;
  logic        s_overflow, s_underflow, s_timeout, s_halted;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  logic [31:0] mq [CHANNELS][$];
  int          m_state, m_wd;
  bit          m_first;
  logic [1:0]  e_mis;
  logic [15:0] e_cnt;
  logic [1:0]  e_fchan;
  logic [31:0] e_fmodel, e_fdut;
  logic        e_ovf, e_unf, e_to, e_halt;
  logic [31:0] r_head;

  initial forever #5 clk = ~clk;

  lockstep_checker #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS), .TIMEOUT(TIMEOUT), .STOP_ON_ERR(0)
  ) dut (
    .Clock(clk), .nReset(rst_n), .Enable(enable),
    .ModelValid(mv), .ModelData(md), .DutValid(dv), .DutData(dd),
    .Mismatch(mismatch), .ErrCount(err_count), .FirstErrChan(first_chan),
    .FirstErrModel(first_model), .FirstErrDut(first_dut),
    .Overflow(overflow), .Underflow(underflow), .Timeout(timeout), .Halted(halted)
  );

  lockstep_checker #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS), .TIMEOUT(20000), .STOP_ON_ERR(1)
  ) dut_stop (
    .Clock(clk), .nReset(rst_n), .Enable(s_enable),
    .ModelValid(s_mv), .ModelData(s_md), .DutValid(s_dv), .DutData(s_dd),
    .Mismatch(s_mismatch), .ErrCount(s_err_count), .FirstErrChan(s_first_chan),
    .FirstErrModel(s_first_model), .FirstErrDut(s_first_dut),
    .Overflow(s_overflow), .Underflow(s_underflow), .Timeout(s_timeout), .Halted(s_halted)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic note_err(input int c, input logic [31:0] m, input logic [31:0] d);
    if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
    if (!m_first) begin
      m_first  = 1'b1;
      e_fchan  = 2'(c);
      e_fmodel = m;
      e_fdut   = d;
    end
  endtask

  // Expected outputs after the coming edge, from the current inputs.
  task automatic model_step();
    logic        hit;
    logic [31:0] m, d, h;
`ifdef LOCKSTEP_WATCHDOG_EN
    bit          any_ne;
`endif
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) mq[c].delete();
      m_state = S_IDLE; m_wd = 0; m_first = 1'b0;
      e_mis = '0; e_cnt = '0; e_fchan = '0; e_fmodel = '0; e_fdut = '0;
      e_ovf = 1'b0; e_unf = 1'b0; e_to = 1'b0; e_halt = 1'b0;
      return;
    end
    hit   = 1'b0;
    e_mis = '0;
`ifdef LOCKSTEP_WATCHDOG_EN
    any_ne = 1'b0;
    for (int c = 0; c < CHANNELS; c++) if (mq[c].size() != 0) any_ne = 1'b1;
`endif
    if (m_state == S_RUN) begin
      for (int c = 0; c < CHANNELS; c++) begin
        m = md[c*32 +: 32];
        d = dd[c*32 +: 32];
        if (dv[c]) begin
          if (mq[c].size() == 0) begin
            if (mv[c]) begin
              if (m != d) begin e_mis[c] = 1'b1; note_err(c, m, d); end
            end else begin
              e_unf = 1'b1;
              note_err(c, 32'h0, d);
            end
          end else begin
            h = mq[c].pop_front();
            if (h != d) begin e_mis[c] = 1'b1; note_err(c, h, d); end
            if (mv[c]) mq[c].push_back(m);
          end
        end else if (mv[c]) begin
          if (mq[c].size() == DEPTH) begin
            e_ovf = 1'b1;
            note_err(c, m, 32'h0);
          end else begin
            mq[c].push_back(m);
          end
        end
      end
    end
`ifdef LOCKSTEP_WATCHDOG_EN
    if (dv != 2'b00 || !any_ne) m_wd = 0;
    else if (m_state == S_RUN) begin
      if (m_wd == TIMEOUT - 1) hit = 1'b1;
      m_wd++;
    end
`endif
    case (m_state)
      S_IDLE: if (enable) m_state = S_RUN;
      S_RUN: begin
        if (hit) begin m_state = S_HALT; e_to = 1'b1; end
        else if (!enable) m_state = S_IDLE;
      end
      default: m_state = S_HALT;
    endcase
    e_halt = (m_state == S_HALT);
  endtask

  task automatic compare_all();
    check("mismatch",    64'(mismatch),    64'(e_mis));
    check("err_count",   64'(err_count),   64'(e_cnt));
    check("first_chan",  64'(first_chan),  64'(e_fchan));
    check("first_model", 64'(first_model), 64'(e_fmodel));
    check("first_dut",   64'(first_dut),   64'(e_fdut));
    check("overflow",    64'(overflow),    64'(e_ovf));
    check("underflow",   64'(underflow),   64'(e_unf));
    check("timeout",     64'(timeout),     64'(e_to));
    check("halted",      64'(halted),      64'(e_halt));
  endtask

  // One clock: compare last edge's outputs mid-cycle, advance the model, cross the edge.
  task automatic step();
    @(negedge clk);
    if (chk_en) compare_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [1:0] v_m, input logic [31:0] m0, input logic [31:0] m1,
                     input logic [1:0] v_d, input logic [31:0] d0, input logic [31:0] d1);
    mv = v_m; md = {m1, m0};
    dv = v_d; dd = {d1, d0};
    step();
  endtask

  task automatic scyc(input logic [1:0] v_m, input logic [31:0] m0, input logic [31:0] m1,
                      input logic [1:0] v_d, input logic [31:0] d0, input logic [31:0] d1);
    s_mv = v_m; s_md = {m1, m0};
    s_dv = v_d; s_dd = {d1, d0};
    step();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; mv = '0; dv = '0; md = '0; dd = '0;
    s_enable = 1'b0; s_mv = '0; s_dv = '0; s_md = '0; s_dd = '0;
    step();
    step();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    check("reset_err_count", 64'(err_count), 64'h0);
    check("reset_halted", 64'(halted), 64'h0);

    // STOP_ON_ERR instance: two simultaneous mismatches, then halt.
    s_enable = 1'b1;
    scyc(2'b00, 0, 0, 2'b00, 0, 0);
    scyc(2'b11, 32'hA0, 32'hB0, 2'b00, 0, 0);
    scyc(2'b00, 0, 0, 2'b11, 32'hA1, 32'hB1);
    check("stop_mismatch", 64'(s_mismatch), 64'h3);
    check("stop_err_count", 64'(s_err_count), 64'h2);
    check("stop_first_chan", 64'(s_first_chan), 64'h0);
    check("stop_first_model", 64'(s_first_model), 64'hA0);
    check("stop_first_dut", 64'(s_first_dut), 64'hA1);
    check("stop_not_halted_yet", 64'(s_halted), 64'h0);
    scyc(2'b00, 0, 0, 2'b00, 0, 0);
    check("stop_halted", 64'(s_halted), 64'h1);
    check("stop_err_count_held", 64'(s_err_count), 64'h2);
    scyc(2'b11, 32'h1, 32'h2, 2'b11, 32'h3, 32'h4);
    check("stop_ignored_count", 64'(s_err_count), 64'h2);
    check("stop_ignored_mismatch", 64'(s_mismatch), 64'h0);
    s_enable = 1'b0;
    scyc(2'b00, 0, 0, 2'b00, 0, 0);

    // In-order match with 2-cycle skew on ch0.
    enable = 1'b1;
    cyc(2'b00, 0, 0, 2'b00, 0, 0);
    cyc(2'b01, 32'h10, 0, 2'b00, 0, 0);
    cyc(2'b01, 32'h14, 0, 2'b00, 0, 0);
    cyc(2'b01, 32'h18, 0, 2'b01, 32'h10, 0);
    cyc(2'b00, 0, 0, 2'b01, 32'h14, 0);
    cyc(2'b00, 0, 0, 2'b01, 32'h18, 0);
    check("skew_err_count", 64'(err_count), 64'h0);
    check("skew_mismatch", 64'(mismatch), 64'h0);
    check("skew_flags", 64'({overflow, underflow}), 64'h0);

    // Single mismatch on ch1.
    cyc(2'b10, 0, 32'hDEADBEEF, 2'b00, 0, 0);
    cyc(2'b00, 0, 0, 2'b10, 0, 32'hDEADBEEE);
    check("mis_pulse", 64'(mismatch), 64'h2);
    check("mis_err_count", 64'(err_count), 64'h1);
    check("mis_first_chan", 64'(first_chan), 64'h1);
    check("mis_first_model", 64'(first_model), 64'hDEADBEEF);
    check("mis_first_dut", 64'(first_dut), 64'hDEADBEEE);
    cyc(2'b00, 0, 0, 2'b00, 0, 0);
    check("mis_pulse_end", 64'(mismatch), 64'h0);

    // Overflow on ch0, then a legal push+pop while full, then drain.
    for (int i = 1; i <= 5; i++) cyc(2'b01, 32'(i), 0, 2'b00, 0, 0);
    check("ovf_flag", 64'(overflow), 64'h1);
    check("ovf_err_count", 64'(err_count), 64'h2);
    cyc(2'b01, 32'h6, 0, 2'b01, 32'h1, 0);
    check("full_push_pop_count", 64'(err_count), 64'h2);
    cyc(2'b00, 0, 0, 2'b01, 32'h2, 0);
    cyc(2'b00, 0, 0, 2'b01, 32'h3, 0);
    cyc(2'b00, 0, 0, 2'b01, 32'h4, 0);
    cyc(2'b00, 0, 0, 2'b01, 32'h6, 0);
    check("drain_err_count", 64'(err_count), 64'h2);
    check("first_err_kept", 64'(first_model), 64'hDEADBEEF);

    // Underflow on empty ch0, then bypass on empty ch1.
    cyc(2'b00, 0, 0, 2'b01, 32'h99, 0);
    check("unf_flag", 64'(underflow), 64'h1);
    check("unf_err_count", 64'(err_count), 64'h3);
    check("unf_no_mismatch", 64'(mismatch), 64'h0);
    cyc(2'b10, 0, 32'h5, 2'b10, 0, 32'h5);
    check("bypass_err_count", 64'(err_count), 64'h3);
    check("bypass_mismatch", 64'(mismatch), 64'h0);

    // Stall with one pending sample.
    cyc(2'b01, 32'h77, 0, 2'b00, 0, 0);
`ifdef LOCKSTEP_WATCHDOG_EN
    repeat (15) cyc(2'b00, 0, 0, 2'b00, 0, 0);
    check("wd_not_yet", 64'(timeout), 64'h0);
    cyc(2'b00, 0, 0, 2'b00, 0, 0);
    check("wd_timeout", 64'(timeout), 64'h1);
    check("wd_halted", 64'(halted), 64'h1);
    cyc(2'b00, 0, 0, 2'b10, 0, 32'h1);
    check("halt_ignores", 64'(err_count), 64'h3);
`else
    repeat (20) cyc(2'b00, 0, 0, 2'b00, 0, 0);
    check("no_wd_timeout", 64'(timeout), 64'h0);
    check("no_wd_halted", 64'(halted), 64'h0);
`endif

    // Reset mid-operation flushes FIFOs and status.
    rst_n = 1'b0;
    cyc(2'b00, 0, 0, 2'b00, 0, 0);
    rst_n = 1'b1;
    check("rst_err_count", 64'(err_count), 64'h0);
    check("rst_flags", 64'({mismatch, overflow, underflow, timeout, halted}), 64'h0);
    check("rst_first", 64'({first_chan, first_model, first_dut}), 64'h0);
    cyc(2'b00, 0, 0, 2'b00, 0, 0);
    cyc(2'b00, 0, 0, 2'b01, 32'h77, 0);
    check("rst_flushed", 64'(underflow), 64'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n  = ($urandom_range(0, 249) != 0);
      enable = ($urandom_range(0, 24) != 0);
      for (int c = 0; c < CHANNELS; c++) begin
        mv[c] = 1'($urandom_range(0, 1));
        dv[c] = 1'($urandom_range(0, 1));
        md[c*32 +: 32] = $urandom;
        if (mq[c].size() != 0) r_head = mq[c][0];
        else                   r_head = md[c*32 +: 32];
        if ($urandom_range(0, 11) == 0) dd[c*32 +: 32] = r_head ^ (32'h1 << $urandom_range(0, 31));
        else                            dd[c*32 +: 32] = r_head;
      end
      step();
    end

    // Error counter saturation: two underflows per cycle.
    rst_n = 1'b0; enable = 1'b1;
    cyc(2'b00, 0, 0, 2'b00, 0, 0);
    rst_n = 1'b1;
    cyc(2'b00, 0, 0, 2'b00, 0, 0);
    for (int i = 0; i < 32800; i++) cyc(2'b00, 0, 0, 2'b11, $urandom, $urandom);
    check("sat_err_count", 64'(err_count), 64'hFFFF);
    cyc(2'b00, 0, 0, 2'b00, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
